cnn_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator for the CNN cell array. It accepts one raster-ordered plane of cell values, either inputs U or outputs Y, and emits one zero-padded 3x3 window per cell. The nine window taps connect directly to the cell's 1..9 neighbour ports (U1..U9 or Y1..Y9). It is the producer end of the cell's neighbourhood interface: it writes the windows that the cell-update datapath reads.

---
 rtl/cnn_window_gen.sv | 177 +++++++++++++++++
 tb/tb_cnn_window_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_window_gen.sv
// Streaming 3x3 neighbourhood generator for the CNN cell array.
// Walks a virtual (IMG_H+1) x (IMG_W+1) step grid over one raster-ordered plane,
// shifting real cells or inserted zeros into a 3x3 register window fed by two
// line buffers. It emits one zero-padded window per cell, W1..W9 row-major.
module cnn_window_gen #(
    parameter int WIDTH = 9,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] W1,
    output logic signed [WIDTH-1:0] W2,
    output logic signed [WIDTH-1:0] W3,
    output logic signed [WIDTH-1:0] W4,
    output logic signed [WIDTH-1:0] W5,
    output logic signed [WIDTH-1:0] W6,
    output logic signed [WIDTH-1:0] W7,
    output logic signed [WIDTH-1:0] W8,
    output logic signed [WIDTH-1:0] W9,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_END = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_END = RW'(IMG_H);
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);

    typedef enum logic {
        ST_RUN,
        ST_LAST
    } state_t;

    state_t                  state_q;
    logic [RW-1:0]           vr_q, vr_d;
    logic [CW-1:0]           vc_q, vc_d;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic signed [WIDTH-1:0] tap_q [0:8];
    logic signed [WIDTH-1:0] tap_d [0:8];
    logic signed [WIDTH-1:0] win_q [0:2][0:2];
    logic signed [WIDTH-1:0] win_d [0:2][0:2];
    logic signed [WIDTH-1:0] lb1_q [0:IMG_W];
    logic signed [WIDTH-1:0] lb2_q [0:IMG_W];

    logic                    inputStep;
    logic                    slotFree;
    logic                    advance;
    logic                    emit;
    logic                    finalStep;
    logic signed [WIDTH-1:0] newVal;
    logic signed [WIDTH-1:0] lbUp1;
    logic signed [WIDTH-1:0] lbUp2;
    logic                    maskTop, maskBot, maskLeft, maskRight;

    // Step bookkeeping: which kind of step we are on and whether it may advance this cycle
    always_comb begin
        inputStep = (vr_q < ROW_END) && (vc_q < COL_END);
        slotFree  = !out_valid_q || out_ready;
        advance   = (state_q == ST_RUN) && slotFree && (!inputStep || in_valid);
        emit      = (vr_q != '0) && (vc_q != '0);
        finalStep = (vr_q == ROW_END) && (vc_q == COL_END);
        newVal    = inputStep ? in_data : '0;
        lbUp1     = lb1_q[vc_q];
        lbUp2     = lb2_q[vc_q];
        in_ready  = (state_q == ST_RUN) && inputStep && slotFree && !rst;
    end

    // Next grid position; the final step wraps straight back to the frame origin
    always_comb begin
        vr_d = vr_q;
        vc_d = vc_q + COL_ONE;
        if (vc_q == COL_END) begin
            vc_d = '0;
            vr_d = finalStep ? '0 : vr_q + ROW_ONE;
        end
    end

    // Shifted window and its zero-padded tap image; stale buffer rows and wrapped columns are masked here
    always_comb begin
        maskTop   = (vr_q == ROW_ONE);
        maskBot   = (vr_q == ROW_END);
        maskLeft  = (vc_q == COL_ONE);
        maskRight = (vc_q == COL_END);
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lbUp2;
        win_d[1][2] = lbUp1;
        win_d[2][2] = newVal;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                tap_d[r*3 + c] = win_d[r][c];
                if ((r == 0 && maskTop) || (r == 2 && maskBot) ||
                    (c == 0 && maskLeft) || (c == 2 && maskRight)) begin
                    tap_d[r*3 + c] = '0;
                end
            end
        end
    end

    // Window registers and line buffers; indexed by column so each buffer returns the same column one row up
    always_ff @(posedge clk) begin
        if (advance) begin
            win_q        <= win_d;
            lb1_q[vc_q]  <= newVal;
            lb2_q[vc_q]  <= lbUp1;
        end
    end

    // Control FSM: steps the grid, loads the registered window, and holds the last window until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            vr_q        <= '0;
            vc_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (advance) begin
                        vr_q <= vr_d;
                        vc_q <= vc_d;
                        if (emit) begin
                            tap_q       <= tap_d;
                            out_valid_q <= 1'b1;
                            out_last_q  <= finalStep;
                        end
                        if (finalStep) begin
                            state_q <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    if (out_valid_q && out_ready && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        vr_q        <= '0;
                        vc_q        <= '0;
                        state_q     <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign W1 = tap_q[0];
    assign W2 = tap_q[1];
    assign W3 = tap_q[2];
    assign W4 = tap_q[3];
    assign W5 = tap_q[4];
    assign W6 = tap_q[5];
    assign W7 = tap_q[6];
    assign W8 = tap_q[7];
    assign W9 = tap_q[8];

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen on a 4x3 plane: a frame-level window
// model feeds a scoreboard that a single monitor compares every taken window to.
module tb_cnn_window_gen;

    localparam int TW   = 9;
    localparam int TIW  = 4;
    localparam int TIH  = 3;
    localparam int NPIX = TIW * TIH;

    typedef logic [9*TW-1:0] win_t;
    typedef struct {
        win_t w;
        bit   last;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic signed [TW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [TW-1:0] W1, W2, W3, W4, W5, W6, W7, W8, W9;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    win_t                 dutWin;

    exp_t expQ[$];
    win_t capWin [NPIX];
    int   img [TIH][TIW];

    int   checks = 0;
    int   errors = 0;
    int   cycleNo = 0;
    int   accCount = 0;
    int   frameTaken = 0;
    int   framesDone = 0;
    int   acceptCycle = -100;
    bit   seenValid = 0;
    bit   prevStall = 0;
    bit   prevLast = 0;
    win_t prevWin = '0;
    bit   readyRandom = 0;

    cnn_window_gen #(
        .WIDTH(TW),
        .IMG_W(TIW),
        .IMG_H(TIH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .W1       (W1),
        .W2       (W2),
        .W3       (W3),
        .W4       (W4),
        .W5       (W5),
        .W6       (W6),
        .W7       (W7),
        .W8       (W8),
        .W9       (W9),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    assign dutWin = {W9, W8, W7, W6, W5, W4, W3, W2, W1};

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Window of the current image centred on (r,c), zero outside the plane
    function automatic win_t modelWindow(input int r, input int c);
        win_t w;
        int   v;
        w = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                v = 0;
                if (r + dr >= 0 && r + dr < TIH && c + dc >= 0 && c + dc < TIW) begin
                    v = img[r+dr][c+dc];
                end
                w[((dr+1)*3 + (dc+1))*TW +: TW] = v[TW-1:0];
            end
        end
        return w;
    endfunction

    // Packs nine tap literals W1..W9 into a window word
    function automatic win_t mkWin(input int t0, input int t1, input int t2,
                                   input int t3, input int t4, input int t5,
                                   input int t6, input int t7, input int t8);
        int   t [9];
        win_t w;
        t = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*TW +: TW] = t[k][TW-1:0];
        end
        return w;
    endfunction

    // Consumer handshake: always ready, or randomly back-pressuring
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = readyRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: reset values, input acceptance position, stall stability and every taken window
    initial begin
        forever begin
            @(negedge clk);
            cycleNo++;
            if (rst) begin
                checks++;
                if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0 || dutWin !== '0) begin
                    errors++;
                    $display("[TB] FAIL resetOutputs: valid=%0b last=%0b ready=%0b taps=%h, required all zero",
                             out_valid, out_last, in_ready, dutWin);
                end
                expQ.delete();
                accCount    = 0;
                frameTaken  = 0;
                seenValid   = 0;
                prevStall   = 0;
                acceptCycle = -100;
            end else begin
                if (in_ready) begin
                    checks++;
                    if (accCount >= NPIX || (out_valid && !out_ready)) begin
                        errors++;
                        $display("[TB] FAIL readyWhenIllegal: in_ready=1 with %0d cells taken, stall=%0b, required 0",
                                 accCount, out_valid && !out_ready);
                    end
                end
                if (in_valid && in_ready) begin
                    int r, c, expLoaded, gotLoaded;
                    r = accCount / TIW;
                    c = accCount % TIW;
                    expLoaded = (r == 0) ? 0 : (r - 1) * TIW + ((c > 0) ? c - 1 : 0);
                    gotLoaded = frameTaken + (out_valid ? 1 : 0);
                    checks++;
                    if (gotLoaded != expLoaded) begin
                        errors++;
                        $display("[TB] FAIL windowsBeforeCell(%0d,%0d): got %0d, required %0d",
                                 r, c, gotLoaded, expLoaded);
                    end
                    if (accCount == TIW + 1) acceptCycle = cycleNo;
                    accCount++;
                end
                if (out_valid && !seenValid) begin
                    seenValid = 1;
                    checks++;
                    if (cycleNo != acceptCycle + 1) begin
                        errors++;
                        $display("[TB] FAIL firstValidTiming: cycle %0d, required %0d",
                                 cycleNo, acceptCycle + 1);
                    end
                end
                if (prevStall) begin
                    checks++;
                    if (out_valid !== 1'b1 || dutWin !== prevWin || out_last !== prevLast) begin
                        errors++;
                        $display("[TB] FAIL stallHold: valid=%0b last=%0b taps=%h, required 1 %0b %h",
                                 out_valid, out_last, dutWin, prevLast, prevWin);
                    end
                end
                if (out_valid && out_ready) begin
                    exp_t e;
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpectedWindow: taps=%h, required no window", dutWin);
                    end else begin
                        e = expQ.pop_front();
                        if (dutWin !== e.w || out_last !== e.last) begin
                            errors++;
                            $display("[TB] FAIL window%0d: taps=%h last=%0b, required %h last=%0b",
                                     frameTaken, dutWin, out_last, e.w, e.last);
                        end
                    end
                    if (frameTaken < NPIX) capWin[frameTaken] = dutWin;
                    frameTaken++;
                    if (out_last) begin
                        checks++;
                        if (frameTaken != NPIX) begin
                            errors++;
                            $display("[TB] FAIL windowsPerFrame: got %0d, required %0d", frameTaken, NPIX);
                        end
                        framesDone++;
                        frameTaken  = 0;
                        accCount    = 0;
                        seenValid   = 0;
                        acceptCycle = -100;
                    end
                end
                prevStall = out_valid && !out_ready;
                prevWin   = dutWin;
                prevLast  = out_last;
            end
        end
    end

    // Loads a frame (counting up from base, or random signed), queues its model windows, sends nCells
    task automatic applyStimulus(input int mode, input int base, input bit gaps, input int nCells);
        for (int r = 0; r < TIH; r++) begin
            for (int c = 0; c < TIW; c++) begin
                img[r][c] = (mode == 0) ? base + r * TIW + c : int'($urandom_range(0, 511)) - 256;
            end
        end
        for (int r = 0; r < TIH; r++) begin
            for (int c = 0; c < TIW; c++) begin
                exp_t e;
                e.w    = modelWindow(r, c);
                e.last = (r == TIH - 1) && (c == TIW - 1);
                expQ.push_back(e);
            end
        end
        for (int k = 0; k < nCells; k++) begin
            int  n;
            bit  accepted;
            int  v;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            v        = img[k / TIW][k % TIW];
            in_data  = v[TW-1:0];
            in_valid = 1'b1;
            n        = 0;
            accepted = 0;
            while (!accepted && n < 500) begin
                @(negedge clk);
                accepted = in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!accepted) begin
                checks++;
                errors++;
                $display("[TB] FAIL acceptTimeout: cell %0d never accepted, required acceptance", k);
            end
        end
        in_valid = 1'b0;
    endtask

    // Bounded wait until the monitor has seen the given number of completed frames
    task automatic waitFrames(input int target);
        int n;
        n = 0;
        while (framesDone < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (framesDone < target) begin
            errors++;
            $display("[TB] FAIL frameTimeout: frames=%0d, required %0d", framesDone, target);
        end
    endtask

    // Compares one captured window of the latest frame with a hand-computed literal
    task automatic checkOutput(input string name, input int idx, input win_t expected);
        checks++;
        if (capWin[idx] !== expected) begin
            errors++;
            $display("[TB] FAIL %s: taps=%h, required %h", name, capWin[idx], expected);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] frame 1..12, unstalled");
        applyStimulus(0, 1, 0, NPIX);
        waitFrames(1);
        checkOutput("firstWindow", 0, mkWin(0, 0, 0, 0, 1, 2, 0, 5, 6));
        checkOutput("centre1_0", 4, mkWin(0, 1, 2, 0, 5, 6, 0, 9, 10));
        checkOutput("lastWindow", NPIX - 1, mkWin(7, 8, 0, 11, 12, 0, 0, 0, 0));

        $display("[TB] frame 1..12 with random gaps and back-pressure");
        readyRandom = 1;
        applyStimulus(0, 1, 1, NPIX);
        waitFrames(2);
        readyRandom = 0;

        $display("[TB] back-to-back frames 1..12 and 101..112");
        applyStimulus(0, 1, 0, NPIX);
        applyStimulus(0, 101, 0, NPIX);
        waitFrames(4);
        checkOutput("frame2First", 0, mkWin(0, 0, 0, 0, 101, 102, 0, 105, 106));

        $display("[TB] random signed frames with random gaps and back-pressure");
        readyRandom = 1;
        applyStimulus(1, 0, 1, NPIX);
        applyStimulus(1, 0, 1, NPIX);
        waitFrames(6);
        readyRandom = 0;

        $display("[TB] reset after cell 7, then fresh frame 1..12");
        applyStimulus(0, 1, 0, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 1, 0, NPIX);
        waitFrames(7);
        checkOutput("replayFirst", 0, mkWin(0, 0, 0, 0, 1, 2, 0, 5, 6));
        checkOutput("replayCentre1_0", 4, mkWin(0, 1, 2, 0, 5, 6, 0, 9, 10));
        checkOutput("replayLast", NPIX - 1, mkWin(7, 8, 0, 11, 12, 0, 0, 0, 0));

        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftoverWindows: %0d still expected, required 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
